fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised decoupling FIFO between instruction fetch and decode for the pipelined core.
//  It holds up to DEPTH {PC, PC+4, instruction} triples so fetch can run ahead while decode stalls.
//  It replaces the single fetch/decode pipeline register with a valid/ready queue.
//  A redirect flush from the branch stage empties the queue in one cycle.
// PARAMETERS
//  XLEN   32  width of PC and instruction words
//  DEPTH  4   entry count; power of two, >= 2
// PORTS
//  clk          in   1              rising-edge clock
//  reset        in   1              synchronous, active-high; empties queue
//  flush        in   1              redirect: discard all entries and any same-cycle push
//  in_valid     in   1              fetch offers an entry
//  in_ready     out  1              queue can accept; equals !full
//  in_pc        in   XLEN           PC of offered instruction
//  in_instr     in   XLEN           offered instruction word
//  out_valid    out  1              head entry valid; equals !empty
//  out_ready    in   1              decode consumes head this cycle
//  out_pc       out  XLEN           head PC
//  out_pcplus4  out  XLEN           head PC + 4, computed at push and stored
//  out_instr    out  XLEN           head instruction
//  count        out  $clog2(DEPTH)+1 occupancy, 0..DEPTH
// BEHAVIOUR
//  - Storage: DEPTH-entry circular buffer. Read and write pointers are $clog2(DEPTH)+1 bits wide.
//    The MSB is the wrap bit. empty = (rd == wr). full = index bits equal and wrap bits differ.
//  - push = in_valid & in_ready & !flush. pop = out_valid & out_ready & !flush.
//  - A push writes {in_pc, in_pc+4, in_instr} at wr[idx], and wr increments on that clock edge.
//    in_pc+4 is computed modulo 2^XLEN, so 0xFFFFFFFC gives 0x00000000.
//  - A pop increments rd on the clock edge. Head outputs are driven combinationally from mem[rd[idx]].
//  - Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N.
//    There is no same-cycle bypass from empty.
//  - in_ready = !full. It does not depend on out_ready, so there is no comb path from decode to fetch.
//    Push is refused when full, even if a pop happens in the same cycle.
//  - Simultaneous push and pop when not full and not empty: both pointers advance and count is unchanged.
//  - Push and pop with count == 1: the popped entry leaves and the new entry becomes head next cycle.
//  - Pointer wrap-around follows natural modular increment. Ordering is preserved across the wrap.
//  - flush: on the edge, rd <= wr, count <= 0 and out_valid = 0 next cycle.
//    A concurrent push or pop is ignored. Storage contents are not cleared.
//  - reset: on the edge, rd = wr = 0 and count = 0. After reset: out_valid = 0, in_ready = 1 and count = 0.
//    out_pc, out_pcplus4 and out_instr are don't-care while out_valid = 0.
//    Reset takes priority over flush, push and pop, and discards any in-flight entries when asserted mid-operation.
//  - count is kept as a register: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Behaviour changes on the clock edge only. No latch. No async paths.
// TESTING
//  1. Reset, then push PC=0x0/0x4/0x8 with out_ready=0.
//     -> count=3; out_pc=0x0, out_pcplus4=0x4 and out_instr match the first push.
//  2. With DEPTH=4, push 4 entries with out_ready=0.
//     -> in_ready=0 and count=4. A 5th in_valid is dropped. Draining returns the 4 entries in order.
//  3. Stream 10 entries with in_valid=out_ready=1 throughout.
//     -> pointers wrap twice. Output order is PC 0x0..0x24, and count holds at 1 in steady state.
//  4. Load 3 entries, then assert flush together with in_valid (PC=0x100).
//     -> next cycle out_valid=0 and count=0. PC 0x100 is never emitted. A following push of 0x200 appears as head.
//  5. Push in_pc=0xFFFFFFFC.
//     -> out_pcplus4=0x00000000.
//  6. Load 2 entries, then assert reset for 1 cycle with in_valid=1.
//     -> count=0, out_valid=0 and in_ready=1. No entry survives.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue interface.
// Carries the fetch-side push channel, the decode-side pop channel, the
// redirect flush and the occupancy count. clk and reset stay plain ports.
interface fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pcplus4;
    logic [XLEN-1:0] out_instr;
    logic [CW-1:0]   count;

    // Fetch/branch/decode environment side
    modport master (
        output flush,
        output in_valid,
        output in_pc,
        output in_instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_pc,
        input  out_pcplus4,
        input  out_instr,
        input  count
    );

    // Queue side
    modport slave (
        input  flush,
        input  in_valid,
        input  in_pc,
        input  in_instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_pc,
        output out_pcplus4,
        output out_instr,
        output count
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode.
// Holds up to DEPTH {pc, pc+4, instr} triples in a circular buffer. Pointers
// carry an extra wrap bit so full and empty are distinguishable without the
// count register; count is kept separately as an explicit occupancy output.
// in_ready depends only on queue state, never on out_ready.
module fetch_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [XLEN-1:0] PcStep = XLEN'(4);

    typedef logic [CW-1:0] ptr_t;

    ptr_t rd_q, rd_d;
    ptr_t wr_q, wr_d;
    ptr_t count_q, count_d;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] pc4_mem   [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign rd_idx = rd_q[AW-1:0];
    assign wr_idx = wr_q[AW-1:0];

    // Occupancy flags from pointer comparison and qualified handshakes
    always_comb begin
        empty = (rd_q == wr_q);
        full  = (rd_idx == wr_idx) && (rd_q[AW] != wr_q[AW]);
        push  = bus.in_valid && !full && !bus.flush;
        pop   = !empty && bus.out_ready && !bus.flush;
    end

    // Next pointer and count state; flush snaps rd onto wr and drops any handshake
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (bus.flush) begin
            rd_d    = wr_q;
            count_d = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_d = rd_q + ptr_t'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + ptr_t'(1);
                2'b01:   count_d = count_q - ptr_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are never cleared, only the pointers move
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[wr_idx]    <= bus.in_pc;
            pc4_mem[wr_idx]   <= bus.in_pc + PcStep;
            instr_mem[wr_idx] <= bus.in_instr;
        end
    end

    // Head outputs read straight from storage; no bypass from an empty queue
    always_comb begin
        bus.in_ready    = !full;
        bus.out_valid   = !empty;
        bus.out_pc      = pc_mem[rd_idx];
        bus.out_pcplus4 = pc4_mem[rd_idx];
        bus.out_instr   = instr_mem[rd_idx];
        bus.count       = count_q;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue.
// Reference model: a plain queue of {pc, pc+4, instr} entries capped at DEPTH.
// The stimulus process updates the model after each cycle's decision point;
// a separate monitor compares the DUT head against the model front and pops
// it when decode consumes.
module tb_fetch_queue;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic reset;
    bit   checking;
    int   vectors;
    int   miscompares;
    ent_t sb[$];

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %08h want %08h at %0t", name, got, want, $time);
        end
    endtask

    // One cycle: drive, check occupancy, then apply the cycle's effect to the model
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                        input bit rdy, input bit fl, input bit rs);
        bit was_full;
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = rdy;
        bus.flush     = fl;
        reset         = rs;
        #1;
        was_full = (sb.size() >= DEPTH);
        if (checking) begin
            check("count", 32'(bus.count), 32'(sb.size()));
            check("in_ready", 32'(bus.in_ready), 32'(!was_full));
        end
        @(negedge clk);
        #1;
        if (rs || fl) begin
            sb.delete();
        end else if (v && !was_full) begin
            sb.push_back('{pc: pc, pc4: pc + 32'd4, instr: ins});
        end
    endtask

    // Monitor: head must match the model front; consumption pops it
    always @(negedge clk) begin
        if (checking) begin
            check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
            if (bus.out_valid && sb.size() != 0) begin
                check("out_pc", bus.out_pc, sb[0].pc);
                check("out_pcplus4", bus.out_pcplus4, sb[0].pc4);
                check("out_instr", bus.out_instr, sb[0].instr);
                if (bus.out_ready && !bus.flush && !reset) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 15) == 0) begin
            r = 32'hFFFF_FFFC;
        end
        return {r[31:2], 2'b00};
    endfunction

    initial begin
        int rdy_pct;
        vectors       = 0;
        miscompares   = 0;
        checking      = 1'b0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        checking = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // Three pushes held at the head
        for (int i = 0; i < 3; i++) step(1, 32'(i * 4), 32'hA000_0000 + 32'(i), 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Fill to DEPTH, offer one more, then drain
        step(1, 32'hC, 32'hA000_0003, 0, 0, 0);
        step(1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0);
        step(1, 32'h10, 32'hDEAD_BEEF, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0);

        // Continuous streaming across two pointer wraps
        for (int i = 0; i < 10; i++) step(1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);

        // Flush with a concurrent push, then a fresh push becomes head
        for (int i = 0; i < 3; i++) step(1, 32'h40 + 32'(i * 4), 32'hC000_0000 + 32'(i), 0, 0, 0);
        step(1, 32'h100, 32'hC000_0100, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'h200, 32'hC000_0200, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // PC+4 wraps modulo 2^32
        step(1, 32'hFFFF_FFFC, 32'h1234_5678, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Mid-operation reset with in_valid high
        step(1, 32'h300, 32'hD000_0000, 0, 0, 0);
        step(1, 32'h304, 32'hD000_0001, 0, 0, 0);
        step(1, 32'h308, 32'hD000_0002, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Randomised traffic with varying decode back-pressure
        rdy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rdy_pct = $urandom_range(10, 95);
            step($urandom_range(0, 99) < 70, rand_pc(), $urandom,
                 $urandom_range(0, 99) < rdy_pct,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 199) == 0);
        end

        for (int i = 0; i < 2 * DEPTH; i++) step(0, 0, 0, 1, 0, 0);
        check("drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
